// File: rtl/ahb_loader_pkg.sv
// Shared types and bus constants for the AHB-Lite stream loader.
// The state enum, fixed AHB control encodings and header field sizes live here.
package ahb_loader_pkg;

  typedef enum logic [2:0] {
    HDR_ADDR,
    HDR_LEN,
    COLLECT,
    ADDR_PH,
    DATA_PH,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HSIZE_WORD      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  localparam int unsigned ADDR_BYTES = 4;
  localparam int unsigned LEN_BYTES  = 2;

  // Value of the packer byte counter while the final byte of a field is taken.
  function automatic logic [1:0] last_byte_idx(input int unsigned nbytes);
    return 2'(nbytes - 1);
  endfunction

endpackage

// File: rtl/ahb_stream_loader_if.sv
// Byte-stream handshake plus AHB-Lite master bus of the stream loader.
// The master modport is the loader side; the slave modport is the source/bus side.
interface ahb_stream_loader_if #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              ahblm_hready;
  logic              ahblm_hresp;
  logic [W_ADDR-1:0] ahblm_haddr;
  logic              ahblm_hwrite;
  logic [1:0]        ahblm_htrans;
  logic [2:0]        ahblm_hsize;
  logic [2:0]        ahblm_hburst;
  logic [3:0]        ahblm_hprot;
  logic              ahblm_hmastlock;
  logic [W_DATA-1:0] ahblm_hwdata;

  modport master (
    input  in_valid, in_data, ahblm_hready, ahblm_hresp,
    output in_ready, ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
           ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );

  modport slave (
    output in_valid, in_data, ahblm_hready, ahblm_hresp,
    input  in_ready, ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
           ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata
  );
endinterface

// File: rtl/byte_word_packer.sv
// Little-endian byte-to-word shift register with a 2-bit byte counter.
// word_next is the word as it will look after the byte currently offered is loaded.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic [1:0]  count,
  output logic        word_full
);
  logic [31:0] word;

  // Newest byte enters at the top, so after four loads byte 0 sits in [7:0].
  assign word_next = {byte_in, word[31:8]};
  assign word_full = load && (count == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= count + 2'd1;
    end

    if (rst) begin
      word <= '0;
    end else if (load) begin
      word <= word_next;
    end
  end
endmodule

// File: rtl/ahb_stream_loader.sv
// AHB-Lite master that decodes a framed byte image and writes it word by word,
// holding the CPU in reset until the whole image has been written.
module ahb_stream_loader
  import ahb_loader_pkg::*;
#(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  ahb_stream_loader_if.master bus,
  output logic                cpu_rst_req,
  output logic                done,
  output logic                err
);
  loader_state_e     state;
  logic [W_ADDR-1:0] next_addr;
  logic [W_LEN-1:0]  words_left;
  logic [1:0]        htrans;
  logic [W_ADDR-1:0] haddr;
  logic [W_DATA-1:0] hwdata;

  logic              byte_take;
  logic              addr_last;
  logic              len_last;
  logic              word_full;
  logic [1:0]        byte_count;
  logic [31:0]       word_next;
  logic [15:0]       len_field;

  assign bus.in_ready = (state == HDR_ADDR) || (state == HDR_LEN) || (state == COLLECT);
  assign byte_take    = bus.in_valid && bus.in_ready;
  assign addr_last    = byte_take && (byte_count == last_byte_idx(ADDR_BYTES));
  assign len_last     = byte_take && (state == HDR_LEN) &&
                        (byte_count == last_byte_idx(LEN_BYTES));
  // Two length bytes land in the upper half of the shift register.
  assign len_field    = word_next[31:16];

  // The length field is only two bytes, so the counter is realigned after it.
  byte_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (len_last),
    .load      (byte_take),
    .byte_in   (bus.in_data),
    .word_next (word_next),
    .count     (byte_count),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HDR_ADDR;
      next_addr   <= '0;
      words_left  <= '0;
      htrans      <= HTRANS_IDLE;
      haddr       <= '0;
      hwdata      <= '0;
      cpu_rst_req <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        HDR_ADDR: begin
          if (addr_last) begin
            next_addr <= {word_next[W_ADDR-1:2], 2'b00};
            state     <= HDR_LEN;
          end
        end
        HDR_LEN: begin
          if (len_last) begin
            words_left <= W_LEN'(len_field);
            if (len_field == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              cpu_rst_req <= 1'b0;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (word_full) begin
            haddr  <= next_addr;
            hwdata <= W_DATA'(word_next);
            htrans <= HTRANS_NONSEQ;
            state  <= ADDR_PH;
          end
        end
        ADDR_PH: begin
          if (bus.ahblm_hready) begin
            htrans <= HTRANS_IDLE;
            state  <= DATA_PH;
          end
        end
        DATA_PH: begin
          // An error response aborts on its first cycle, without waiting for hready.
          if (bus.ahblm_hresp) begin
            state <= ERROR;
            err   <= 1'b1;
          end else if (bus.ahblm_hready) begin
            next_addr  <= next_addr + W_ADDR'(4);
            words_left <= words_left - W_LEN'(1);
            if (words_left == W_LEN'(1)) begin
              state       <= DONE;
              done        <= 1'b1;
              cpu_rst_req <= 1'b0;
            end else begin
              state <= COLLECT;
            end
          end
        end
        DONE, ERROR: begin
        end
        default: begin
          state <= HDR_ADDR;
        end
      endcase
    end
  end

  assign bus.ahblm_haddr     = haddr;
  assign bus.ahblm_hwdata    = hwdata;
  assign bus.ahblm_htrans    = htrans;
  assign bus.ahblm_hwrite    = 1'b1;
  assign bus.ahblm_hsize     = HSIZE_WORD;
  assign bus.ahblm_hburst    = HBURST_SINGLE;
  assign bus.ahblm_hprot     = HPROT_DATA_PRIV;
  assign bus.ahblm_hmastlock = 1'b0;
endmodule

// File: tb/tb_ahb_stream_loader.sv
// Randomized bench for ahb_stream_loader: drives framed images, plays an
// AHB-Lite slave with wait states and error responses, and scores every write.
module tb_ahb_stream_loader;
  logic clk = 1'b0;
  logic rst;
  logic cpu_rst_req;
  logic done;
  logic err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_stream_loader_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  ahb_stream_loader #(
    .W_ADDR (32),
    .W_DATA (32),
    .W_LEN  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cpu_rst_req (cpu_rst_req),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return {base[31:2], 2'b00} + 32'(4 * i);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.ahblm_hready = 1'b1;
    bus.ahblm_hresp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_htrans", bus.ahblm_htrans, 2'b00);
    check("rst_haddr", bus.ahblm_haddr, 0);
    check("rst_hwdata", bus.ahblm_hwdata, 0);
    check("rst_cpu_rst_req", cpu_rst_req, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("ctl_fixed", {bus.ahblm_hwrite, bus.ahblm_hsize, bus.ahblm_hburst,
                        bus.ahblm_hprot, bus.ahblm_hmastlock}, {1'b1, 3'b010, 3'b000, 4'b0011, 1'b0});
  endtask

  // wmode: 0 zero-wait, 1 three wait cycles per phase, 2 random waits.
  // err_word < 0 means no error; abort_at > 0 stops after that many accepted bytes.
  task automatic run_frame(input logic [31:0] base, input int n, input int wmode,
                           input int vpct, input int err_word, input int abort_at,
                           input bit fixed);
    logic [7:0]  q[$];
    logic [31:0] words[$];
    logic [31:0] w;
    logic [7:0]  bv;
    logic [31:0] apend, held_addr, held_data;
    logic        hready, hresp, v;
    int acc = 0, wr = 0, aph = 0, wleft = -1, err_stage = 0, tail = 0, cyc = 0;
    bit dp = 0, a_wait = 0, d_wait = 0, exp_ns = 0;
    bit exp_done = 0, exp_err = 0, done_pend = 0, err_pend = 0, aborted = 0;
    apend = '0; held_addr = '0; held_data = '0;

    for (int b = 0; b < 4; b++) q.push_back(base[8*b +: 8]);
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        bv = fixed ? 8'(17 * (4 * i + b + 1)) : 8'($urandom);
        w[8*b +: 8] = bv;
        q.push_back(bv);
      end
      words.push_back(w);
    end
    for (int j = 0; j < 4; j++) q.push_back(8'($urandom));

    forever begin
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && acc == abort_at) begin
        bus.in_valid = 1'b0;
        aborted = 1;
        break;
      end
      if (done_pend) exp_done = 1;
      if (err_pend)  exp_err  = 1;
      done_pend = 0;
      err_pend  = 0;

      check("done", done, exp_done);
      check("cpu_rst_req", cpu_rst_req, !exp_done);
      check("err", err, exp_err);
      if (exp_done || exp_err) begin
        check("terminal_htrans", bus.ahblm_htrans, 2'b00);
        check("terminal_in_ready", bus.in_ready, 0);
      end
      if (exp_ns) begin
        check("nonseq_latency", bus.ahblm_htrans, 2'b10);
        exp_ns = 0;
      end
      if (bus.ahblm_htrans == 2'b10 || dp) check("busy_in_ready", bus.in_ready, 0);
      if (bus.ahblm_htrans == 2'b10) begin
        if (a_wait) check("haddr_hold", bus.ahblm_haddr, held_addr);
        else        check("haddr", bus.ahblm_haddr, exp_addr(base, aph));
        held_addr = bus.ahblm_haddr;
      end
      if (dp) begin
        if (d_wait) check("hwdata_hold", bus.ahblm_hwdata, held_data);
        held_data = bus.ahblm_hwdata;
      end

      // Slave response for the cycle ending at the next rising edge.
      hresp = 1'b0;
      if (dp && wr == err_word && err_stage == 0) begin
        hready = 1'b0; hresp = 1'b1; err_stage = 1; err_pend = 1;
      end else if (err_stage == 1) begin
        hready = 1'b1; hresp = 1'b1; err_stage = 2;
      end else if (bus.ahblm_htrans != 2'b10 && !dp) begin
        hready = 1'b1; wleft = -1;
      end else begin
        if (wleft < 0) wleft = (wmode == 1) ? 3 : (wmode == 2) ? int'($urandom_range(0, 2)) : 0;
        if (wleft > 0) begin hready = 1'b0; wleft--; end
        else hready = 1'b1;
      end
      bus.ahblm_hready = hready;
      bus.ahblm_hresp  = hresp;

      if (dp) begin
        if (hresp) begin
          if (hready) dp = 0;
        end else if (hready) begin
          if (wr < n) begin
            check("wr_addr", apend, exp_addr(base, wr));
            check("wr_data", bus.ahblm_hwdata, words[wr]);
          end else begin
            check("extra_write", wr, n);
          end
          wr++;
          if (wr == n) done_pend = 1;
          dp = 0;
          wleft = -1;
        end
      end
      d_wait = dp;
      if (bus.ahblm_htrans == 2'b10) begin
        if (hready) begin
          apend = bus.ahblm_haddr; aph++; dp = 1; a_wait = 0; wleft = -1;
        end else a_wait = 1;
      end else a_wait = 0;

      if (q.size() > 0) begin
        v = ($urandom_range(0, 99) < vpct);
        bus.in_valid = v;
        bus.in_data  = q[0];
        if (v && bus.in_ready) begin
          void'(q.pop_front());
          acc++;
          if (acc == 6 && n == 0) done_pend = 1;
          if (acc > 6 && (acc - 6) % 4 == 0) exp_ns = 1;
        end
      end else begin
        bus.in_valid = 1'b0;
      end

      if (exp_done || exp_err) tail++;
      if (tail >= 6) break;
      if (cyc > 20000) begin
        check("timeout", 0, 1);
        break;
      end
    end

    if (!aborted) begin
      check("write_count", wr, (err_word >= 0) ? err_word : n);
      check("aphase_count", aph, (err_word >= 0) ? err_word + 1 : n);
      check("final_done", done, (err_word < 0));
      check("final_err", err, (err_word >= 0));
      check("final_cpu_rst_req", cpu_rst_req, (err_word >= 0));
    end
  endtask

  initial begin
    int n, ew;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.ahblm_hready = 1'b1;
    bus.ahblm_hresp = 1'b0;

    do_reset(); run_frame(32'h0000_0100, 2, 0, 100, -1, 0, 1);
    do_reset(); run_frame(32'h0000_0103, 1, 0, 100, -1, 0, 0);
    do_reset(); run_frame(32'h0000_2000, 0, 0, 100, -1, 0, 0);
    do_reset(); run_frame(32'h0000_4000, 3, 1, 100, -1, 0, 0);
    do_reset(); run_frame(32'hFFFF_FFFC, 2, 0, 100, -1, 0, 0);
    do_reset(); run_frame(32'h0000_0200, 3, 0, 100, 0, 0, 0);
    do_reset(); run_frame(32'h0000_0300, 2, 0, 100, -1, 9, 0);
    do_reset(); run_frame(32'h0000_0400, 2, 2, 70, -1, 0, 1);
    for (int t = 0; t < 6; t++) begin
      n  = int'($urandom_range(1, 6));
      ew = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      do_reset(); run_frame($urandom, n, 2, 60, ew, 0, 0);
    end
    do_reset(); run_frame($urandom, 259, 2, 75, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_stream_loader.md
Name: ahb_stream_loader

Overview:
- AHB-Lite master that preloads the execution-test SRAM from a byte stream (bench stimulus or debug UART).
- Replaces hierarchical memory pokes: decodes a framed image, packs little-endian bytes into 32-bit words and issues single-word writes.
- Holds the CPU in reset until the image is written.
- Sits upstream of ahb_sync_sram, time-sharing the bus port with revive_cpu via an external mux selected by cpu_rst_req.

Parameters:
- W_ADDR, 32, AHB address width
- W_DATA, 32, AHB data width; only 32 is supported
- W_LEN, 16, width of the word-count header field

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader accepts byte
- in_data  in  8  stream byte
- ahblm_hready  in  1  bus ready
- ahblm_hresp  in  1  bus error response
- ahblm_haddr  out  W_ADDR  address
- ahblm_hwrite  out  1  always 1
- ahblm_htrans  out  2  IDLE=00, NONSEQ=10
- ahblm_hsize  out  3  fixed 3'b010
- ahblm_hburst  out  3  fixed 3'b000
- ahblm_hprot  out  4  fixed 4'b0011
- ahblm_hmastlock  out  1  fixed 0
- ahblm_hwdata  out  W_DATA  write data
- cpu_rst_req  out  1  high until load completes; also bus mux select
- done  out  1  sticky, image fully written
- err  out  1  sticky, hresp error seen

Behaviour:
- Frame format: 4 address bytes (LE), then 2 length bytes (LE, word count N), then N×4 data bytes (LE).
- Handshake: a byte transfers on the clk edge where in_valid && in_ready.
- Address bits [1:0] are forced to 0. Each word increments the address by 4, wrapping modulo 2^32.
- States:
  - HDR_ADDR: accept 4 bytes, then go to HDR_LEN.
  - HDR_LEN: accept 2 bytes. If N==0, go to DONE; else go to COLLECT.
  - COLLECT: accept 4 bytes into the word buffer, then go to ADDR_PH.
  - ADDR_PH: htrans=NONSEQ with haddr held. When hready is sampled high, go to DATA_PH.
  - DATA_PH: htrans=IDLE, hwdata held. When hready is sampled high, decrement N; if N becomes 0 go to DONE, else go to COLLECT.
  - DONE: terminal, idle bus.
  - ERROR: terminal, idle bus.
- Error: hresp=1 in DATA_PH, on either the first or second error cycle, goes to ERROR and sets err=1. done stays 0 and cpu_rst_req stays 1.
- in_ready=1 only in HDR_ADDR, HDR_LEN and COLLECT; 0 in all other states.
- Latency: the 4th data byte is accepted on edge k. Address phase is visible from cycle k+1. With zero-wait SRAM, the next byte is accepted at k+3 at the earliest.
- All outputs are registered or decoded directly from the state register; no combinational path from in_valid or hready to outputs.
- Reset values:
  - state=HDR_ADDR, htrans=00, haddr=0, hwdata=0
  - in_ready=1 (decoded from HDR_ADDR)
  - cpu_rst_req=1, done=0, err=0
- Reset mid-frame aborts everything, including an in-flight data phase; the partially written image is not undone.
- Bytes presented in DONE or ERROR are not accepted; in_ready=0 until reset.
- N counts down exactly N writes; a maximum N of 2^W_LEN-1 is legal.
- done=1 and cpu_rst_req=0 on the cycle after the last data phase completes.

Decomposition:
- Package ahb_loader_pkg:
  - state enum encoding
  - HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_WORD, HPROT_DATA_PRIV constants
  - header byte counts (ADDR_BYTES=4, LEN_BYTES=2)
- One sub-module, byte_word_packer: shift register plus 2-bit byte counter, with load/clear and word_full output. Used for header address, length and data words.

Test Plan:
- Header addr 0x00000100, N=2, data 11 22 33 44 55 66 77 88 with zero-wait hready:
  - NONSEQ writes to 0x100 with hwdata 0x44332211, then 0x104 with 0x88776655.
  - done rises one cycle after the 2nd data phase; cpu_rst_req falls on the same cycle.
- Address 0x00000103, N=1 -> write goes to 0x100 (low bits forced to 0).
- N=0 header -> no NONSEQ ever issued; done=1 the cycle after the 6th header byte.
- hready low for 3 cycles in both address and data phases -> haddr and hwdata stable throughout, in_ready=0, exactly one write per word.
- Address 0xFFFFFFFC, N=2 -> writes to 0xFFFFFFFC then 0x00000000.
- hresp=1 on the 1st data phase of N=3 -> err=1, state ERROR, no further NONSEQ, done=0, cpu_rst_req=1.
- Reset after 3 data bytes -> loader returns to HDR_ADDR; a fresh frame then completes normally.
